// File: rtl/banco_fifos_vc_if.sv
// ---------------------------------------------------------------------------
// banco_fifos_vc_if
//   Bundle of all per-channel signals between the packet source, the
//   pop/select counter stage and the four-channel FIFO bank.
//
//   Build option: FIFO_ERR_EN adds the sticky error flags err0..err3.
//
//   Modports
//     master : packet source / arbiter side (drives push, data_in, pop;
//              observes data_out, valid and the occupancy flags)
//     slave  : FIFO bank side (banco_fifos_vc)
//
//   Handshake: a push is taken when pushN is high and the channel is not
//   full (or a pop is taken in the same cycle); a pop is taken when popN is
//   high and the channel is not empty, and its word appears on data_outN
//   with validN high for exactly one cycle, one clock later.
// ---------------------------------------------------------------------------
interface banco_fifos_vc_if #(
    parameter int DATA_WIDTH = 10
);
    logic                  push0, push1, push2, push3;
    logic [DATA_WIDTH-1:0] data_in0, data_in1, data_in2, data_in3;
    logic                  pop0, pop1, pop2, pop3;
    logic [DATA_WIDTH-1:0] data_out0, data_out1, data_out2, data_out3;
    logic                  valid0, valid1, valid2, valid3;
    logic                  full0, full1, full2, full3;
    logic                  empty0, empty1, empty2, empty3;
    logic                  almost_full0, almost_full1, almost_full2, almost_full3;
    logic                  almost_empty0, almost_empty1, almost_empty2, almost_empty3;
`ifdef FIFO_ERR_EN
    logic                  err0, err1, err2, err3;
`endif

    modport master (
        output push0, push1, push2, push3,
        output data_in0, data_in1, data_in2, data_in3,
        output pop0, pop1, pop2, pop3,
        input  data_out0, data_out1, data_out2, data_out3,
        input  valid0, valid1, valid2, valid3,
        input  full0, full1, full2, full3,
        input  empty0, empty1, empty2, empty3,
        input  almost_full0, almost_full1, almost_full2, almost_full3,
`ifdef FIFO_ERR_EN
        input  err0, err1, err2, err3,
`endif
        input  almost_empty0, almost_empty1, almost_empty2, almost_empty3
    );

    modport slave (
        input  push0, push1, push2, push3,
        input  data_in0, data_in1, data_in2, data_in3,
        input  pop0, pop1, pop2, pop3,
        output data_out0, data_out1, data_out2, data_out3,
        output valid0, valid1, valid2, valid3,
        output full0, full1, full2, full3,
        output empty0, empty1, empty2, empty3,
        output almost_full0, almost_full1, almost_full2, almost_full3,
`ifdef FIFO_ERR_EN
        output err0, err1, err2, err3,
`endif
        output almost_empty0, almost_empty1, almost_empty2, almost_empty3
    );
endinterface

// File: rtl/banco_fifos_vc.sv
// ---------------------------------------------------------------------------
// banco_fifos_vc
//   Four independent virtual-channel FIFOs (VC0..VC3) feeding the pop/select
//   counter stage. Each channel stores DATA_WIDTH-bit words, releases one
//   registered word per accepted pop (latency 1, validN pulse) and publishes
//   registered full/empty/almost_full/almost_empty flags computed from the
//   post-edge occupancy.
//
//   Build option: FIFO_ERR_EN -- when defined, errN goes sticky high the
//   cycle after a dropped push (push on full, no pop) or an ignored pop (pop
//   on empty) and clears only on reset. When undefined those events are
//   silently discarded and no err logic exists.
//
//   Ports
//     clk      in  rising-edge clock
//     reset_L  in  synchronous reset, active low
//     bus      banco_fifos_vc_if.slave: push/data_in/pop in, data_out/valid
//              and occupancy flags out, per channel 0..3
//
//   Parameters: ADDR_WIDTH sets DEPTH = 2**ADDR_WIDTH; the thresholds must
//   satisfy 0 <= ALMOST_EMPTY < ALMOST_FULL <= DEPTH.
// ---------------------------------------------------------------------------
module banco_fifos_vc #(
    parameter int DATA_WIDTH   = 10,
    parameter int ADDR_WIDTH   = 2,
    parameter int ALMOST_FULL  = 3,
    parameter int ALMOST_EMPTY = 1
) (
    input  logic                   clk,
    input  logic                   reset_L,
    banco_fifos_vc_if.slave        bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int OCC_W = ADDR_WIDTH + 1;

    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] AF_OCC    = OCC_W'(ALMOST_FULL);
    localparam logic [OCC_W-1:0] AE_OCC    = OCC_W'(ALMOST_EMPTY);

    // Channel-indexed views of the interface so the datapath is one generate body.
    logic [3:0]            push, pop;
    logic [DATA_WIDTH-1:0] din  [4];
    logic [DATA_WIDTH-1:0] dout [4];
    logic [3:0]            valid, full, empty, afull, aempty;

    assign push = {bus.push3, bus.push2, bus.push1, bus.push0};
    assign pop  = {bus.pop3,  bus.pop2,  bus.pop1,  bus.pop0};
    assign din[0] = bus.data_in0;
    assign din[1] = bus.data_in1;
    assign din[2] = bus.data_in2;
    assign din[3] = bus.data_in3;

    assign bus.data_out0 = dout[0];
    assign bus.data_out1 = dout[1];
    assign bus.data_out2 = dout[2];
    assign bus.data_out3 = dout[3];
    assign {bus.valid3, bus.valid2, bus.valid1, bus.valid0} = valid;
    assign {bus.full3,  bus.full2,  bus.full1,  bus.full0}  = full;
    assign {bus.empty3, bus.empty2, bus.empty1, bus.empty0} = empty;
    assign {bus.almost_full3, bus.almost_full2, bus.almost_full1, bus.almost_full0} = afull;
    assign {bus.almost_empty3, bus.almost_empty2, bus.almost_empty1, bus.almost_empty0} = aempty;

`ifdef FIFO_ERR_EN
    logic [3:0] err;
    assign {bus.err3, bus.err2, bus.err1, bus.err0} = err;
`endif

    for (genvar ch = 0; ch < 4; ch++) begin : g_vc
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
        logic [OCC_W-1:0]      occ, occ_next;
        logic [DATA_WIDTH-1:0] dout_r;
        logic                  valid_r, full_r, empty_r, afull_r, aempty_r;
        logic                  push_ok, pop_ok;

        // Pop is evaluated first: a pop on a full channel frees the slot the
        // same-cycle push uses. A pop on an empty channel never falls through
        // to the word being pushed.
        always_comb begin
            pop_ok   = pop[ch] && !empty_r;
            push_ok  = push[ch] && (!full_r || pop_ok);
            occ_next = occ;
            if (push_ok && !pop_ok) begin
                occ_next = occ + OCC_W'(1);
            end else if (pop_ok && !push_ok) begin
                occ_next = occ - OCC_W'(1);
            end
        end

        // Storage carries no reset; stale words are unreachable once pointers clear.
        always_ff @(posedge clk) begin
            if (push_ok) begin
                mem[wr_ptr] <= din[ch];
            end
        end

        always_ff @(posedge clk) begin
            if (!reset_L) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                occ      <= '0;
                dout_r   <= '0;
                valid_r  <= 1'b0;
                full_r   <= 1'b0;
                empty_r  <= 1'b1;
                afull_r  <= 1'b0;
                aempty_r <= 1'b1;
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                end
                if (pop_ok) begin
                    rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
                    dout_r <= mem[rd_ptr];
                end
                valid_r  <= pop_ok;
                occ      <= occ_next;
                // Flags come from occ_next so they match the post-edge occupancy.
                full_r   <= (occ_next == DEPTH_OCC);
                empty_r  <= (occ_next == '0);
                afull_r  <= (occ_next >= AF_OCC);
                aempty_r <= (occ_next <= AE_OCC);
            end
        end

        assign dout[ch]   = dout_r;
        assign valid[ch]  = valid_r;
        assign full[ch]   = full_r;
        assign empty[ch]  = empty_r;
        assign afull[ch]  = afull_r;
        assign aempty[ch] = aempty_r;

`ifdef FIFO_ERR_EN
        logic err_r;

        always_ff @(posedge clk) begin
            if (!reset_L) begin
                err_r <= 1'b0;
            end else if ((push[ch] && !push_ok) || (pop[ch] && !pop_ok)) begin
                err_r <= 1'b1;
            end
        end

        assign err[ch] = err_r;
`endif
    end

endmodule

// File: tb/tb_banco_fifos_vc.sv
// ---------------------------------------------------------------------------
// tb_banco_fifos_vc
//   Bench for banco_fifos_vc. A reference model (one word queue per channel)
//   advances on every rising edge from the stimulus the bench itself drove;
//   each accepted pop pushes its word into that channel's expected queue.
//   A monitor on the falling edge pops the expected queue whenever validN is
//   high and checks valid, data hold and every flag against the model.
//   Directed scenarios come first, then randomized traffic with occasional
//   resets.
// ---------------------------------------------------------------------------
module tb_banco_fifos_vc;
    localparam int DW    = 10;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic clk = 1'b0;
    logic reset_L;

    always #5 clk = ~clk;

    banco_fifos_vc_if #(.DATA_WIDTH(DW)) bus ();

    banco_fifos_vc #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (2),
        .ALMOST_FULL (AF),
        .ALMOST_EMPTY(AE)
    ) dut (
        .clk    (clk),
        .reset_L(reset_L),
        .bus    (bus)
    );

    // Stimulus as currently driven (the model reads these, never the DUT).
    logic          cur_push [4];
    logic          cur_pop  [4];
    logic [DW-1:0] din_v    [4];

    // Reference model and scoreboard state.
    logic [DW-1:0] m_q   [4][$];
    logic [DW-1:0] exp_q [4][$];
    logic          exp_valid [4];
    logic [DW-1:0] exp_hold  [4];
    logic          exp_err   [4];
    logic          model_ready = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int ch, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vc%0d @%0t: got 0x%0h expected 0x%0h", name, ch, $time, act, exp);
        end
    endtask

    // {valid, full, empty, almost_full, almost_empty, data_out}
    function automatic logic [DW+4:0] rd_ch(input int ch);
        case (ch)
            0: return {bus.valid0, bus.full0, bus.empty0, bus.almost_full0, bus.almost_empty0, bus.data_out0};
            1: return {bus.valid1, bus.full1, bus.empty1, bus.almost_full1, bus.almost_empty1, bus.data_out1};
            2: return {bus.valid2, bus.full2, bus.empty2, bus.almost_full2, bus.almost_empty2, bus.data_out2};
            default: return {bus.valid3, bus.full3, bus.empty3, bus.almost_full3, bus.almost_empty3, bus.data_out3};
        endcase
    endfunction

`ifdef FIFO_ERR_EN
    function automatic logic rd_err(input int ch);
        case (ch)
            0: return bus.err0;
            1: return bus.err1;
            2: return bus.err2;
            default: return bus.err3;
        endcase
    endfunction
`endif

    // ---------------- driver ----------------
    task automatic step(input logic rl, input logic [3:0] pu, input logic [3:0] po);
        reset_L = rl;
        for (int c = 0; c < 4; c++) begin
            cur_push[c] = pu[c];
            cur_pop[c]  = po[c];
        end
        bus.push0 = pu[0]; bus.push1 = pu[1]; bus.push2 = pu[2]; bus.push3 = pu[3];
        bus.pop0  = po[0]; bus.pop1  = po[1]; bus.pop2  = po[2]; bus.pop3  = po[3];
        bus.data_in0 = din_v[0]; bus.data_in1 = din_v[1];
        bus.data_in2 = din_v[2]; bus.data_in3 = din_v[3];
        @(posedge clk);
        #2;
    endtask

    task automatic push_one(input int ch, input logic [DW-1:0] d);
        din_v[ch] = d;
        step(1'b1, 4'(1 << ch), 4'b0000);
    endtask

    task automatic pop_one(input int ch);
        step(1'b1, 4'b0000, 4'(1 << ch));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 4'b0000, 4'b0000);
    endtask

    // ---------------- reference model ----------------
    always @(posedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (!reset_L) begin
                m_q[c].delete();
                exp_q[c].delete();
                exp_valid[c] = 1'b0;
                exp_hold[c]  = '0;
                exp_err[c]   = 1'b0;
            end else begin
                logic pop_ok, push_ok;
                pop_ok  = cur_pop[c] && (m_q[c].size() > 0);
                push_ok = cur_push[c] && ((m_q[c].size() < DEPTH) || pop_ok);
                if ((cur_push[c] && !push_ok) || (cur_pop[c] && !pop_ok)) exp_err[c] = 1'b1;
                exp_valid[c] = pop_ok;
                if (pop_ok) begin
                    exp_hold[c] = m_q[c].pop_front();
                    exp_q[c].push_back(exp_hold[c]);
                end
                if (push_ok) m_q[c].push_back(din_v[c]);
            end
        end
        model_ready = 1'b1;
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (model_ready) begin
            for (int c = 0; c < 4; c++) begin
                logic [DW+4:0] s;
                int occ;
                s   = rd_ch(c);
                occ = m_q[c].size();
                check("valid", c, 32'(s[DW+4]), 32'(exp_valid[c]));
                if (s[DW+4]) begin
                    if (exp_q[c].size() == 0) begin
                        check("unexpected_word", c, 32'(s[DW-1:0]), 32'hFFFF_FFFF);
                    end else begin
                        check("data_out", c, 32'(s[DW-1:0]), 32'(exp_q[c].pop_front()));
                    end
                end else begin
                    check("data_hold", c, 32'(s[DW-1:0]), 32'(exp_hold[c]));
                end
                check("full",         c, 32'(s[DW+3]), 32'(occ == DEPTH));
                check("empty",        c, 32'(s[DW+2]), 32'(occ == 0));
                check("almost_full",  c, 32'(s[DW+1]), 32'(occ >= AF));
                check("almost_empty", c, 32'(s[DW]),   32'(occ <= AE));
`ifdef FIFO_ERR_EN
                check("err", c, 32'(rd_err(c)), 32'(exp_err[c]));
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int c = 0; c < 4; c++) din_v[c] = '0;

        // Reset held two cycles.
        step(1'b0, 4'b0000, 4'b0000);
        step(1'b0, 4'b0000, 4'b0000);
        idle(1);

        // VC0: fill with four words, then drain back to back.
        push_one(0, 10'h3A1);
        push_one(0, 10'h0F2);
        push_one(0, 10'h155);
        push_one(0, 10'h2AA);
        for (int i = 0; i < 4; i++) pop_one(0);
        idle(2);

        // VC1: overflow push is dropped, drain returns the original four.
        push_one(1, 10'h001);
        push_one(1, 10'h002);
        push_one(1, 10'h003);
        push_one(1, 10'h004);
        push_one(1, 10'h111);
        for (int i = 0; i < 4; i++) pop_one(1);
        pop_one(1);
        idle(2);

        // VC2: push+pop on empty -> no fall-through, then pop the word.
        din_v[2] = 10'h222;
        step(1'b1, 4'b0100, 4'b0100);
        pop_one(2);
        idle(2);

        // VC3: full, simultaneous push+pop, then drain with pointer wrap.
        push_one(3, 10'h0A0);
        push_one(3, 10'h0B1);
        push_one(3, 10'h0C2);
        push_one(3, 10'h0D3);
        din_v[3] = 10'h333;
        step(1'b1, 4'b1000, 4'b1000);
        for (int i = 0; i < 4; i++) pop_one(3);
        idle(2);

        // VC0: two words, one-cycle reset, pop returns nothing.
        push_one(0, 10'h155);
        push_one(0, 10'h0AB);
        step(1'b0, 4'b0000, 4'b0000);
        pop_one(0);
        idle(2);

        // Randomized traffic with phase-varied push/pop bias and rare resets.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] pu, po;
            int bias;
            bias = ((i / 250) % 2 == 0) ? 70 : 35;
            for (int c = 0; c < 4; c++) begin
                pu[c]    = ($urandom_range(0, 99) < bias);
                po[c]    = ($urandom_range(0, 99) < (100 - bias));
                din_v[c] = DW'($urandom_range(0, (1 << DW) - 1));
            end
            step(($urandom_range(0, 299) != 0), pu, po);
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
